alu_uart_ctrl: RTL
==================

Name: alu_uart_ctrl

Overview:
Sequencer between the UART RX/TX byte interfaces and the combinational ALU. It collects three bytes in order (operand A, operand B, opcode), drives the ALU, registers the result and sends it back through UART TX. It sits in the UART top level between uart_rx, uart_tx and the alu instance. It adds an inter-byte timeout for frame resync and flags illegal opcodes and overrun.

Parameters:
NB_DATA, 8, data/operand/result width (equals the UART byte width)
NB_OP, 6, ALU opcode width
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one frame; 0 disables the timeout
NB_TIMEOUT, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, a new byte is available
i_tx_done  in  1  one-cycle pulse, TX finished the current byte
o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
o_tx_data  out  NB_DATA  registered ALU result
o_alu_op  out  NB_OP  opcode to ALU (registered)
o_alu_data_A  out  NB_DATA  operand A to ALU (registered)
o_alu_data_B  out  NB_DATA  operand B to ALU (registered)
o_alu_shamt  out  5  equals o_alu_data_B[4:0]
i_alu_result  in  NB_DATA  ALU combinational output
o_busy  out  1  high in every state except WAIT_A
o_timeout  out  1  one-cycle pulse, frame aborted by timeout
o_op_err  out  1  one-cycle pulse, illegal opcode byte accepted
o_overrun  out  1  one-cycle pulse, byte dropped while busy computing or sending

Behaviour:
- Reset (async, i_rst_n=0): state WAIT_A, timeout counter 0, all outputs 0. Release is synchronous to i_clk.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, latch A into o_alu_data_A and go to WAIT_B.
- WAIT_B: on i_rx_done, latch B into o_alu_data_B and go to WAIT_OP.
- WAIT_OP: on i_rx_done, latch o_alu_op = i_rx_data[NB_OP-1:0] and go to EXEC.
  - Legal opcodes: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL.
  - If the low bits are not legal, or i_rx_data[NB_DATA-1:NB_OP] is nonzero, pulse o_op_err in the next cycle. The frame still executes, and the ALU default result is sent.
- EXEC: lasts 1 cycle (ALU settle). At its closing edge, o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to WAIT_A. i_tx_done in any other state is ignored.
- Latency: opcode i_rx_done sampled at edge N gives EXEC during cycle N+1 and o_tx_start during cycle N+2.
- Timeout:
  - The counter runs only in WAIT_B and WAIT_OP, and clears on every accepted byte and on entry to WAIT_A.
  - When the counter reaches TIMEOUT_CYCLES-1 with no i_rx_done, go to WAIT_A, pulse o_timeout and clear the counter.
  - If i_rx_done coincides with the expiring cycle, the byte wins: it is accepted and no timeout occurs.
  - Latched operands are not cleared by a timeout.
- Overrun: i_rx_done in EXEC, SEND or WAIT_TX drops the byte and pulses o_overrun next cycle; state and data are unchanged.
- Reset mid-frame or mid-transmission: immediate return to WAIT_A, partial frame discarded, o_tx_start forced 0.
- Width rules:
  - Operands are passed unmodified, signed interpretation is the ALU's.
  - SRA/SRL shift amount is B; o_alu_shamt is provided for the 5-bit shamt port.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode localparams (ADD_OP … NOR_OP) plus an ALU_OP_LEGAL check function; the ALU and this block both use them.
  - FSM state encodings (3-bit).
  - ALU default result 8'hA1.
- One sub-module: frame_timeout_cnt (parameters TIMEOUT_CYCLES, NB_TIMEOUT; inputs i_clk, i_rst_n, i_run, i_clear; output o_expired pulse). Everything else lives in alu_uart_ctrl.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with TX done 10 cycles after start -> o_tx_data=0x08, one o_tx_start exactly 2 cycles after the opcode rx_done, o_busy low after i_tx_done.
- SUB 0x03, 0x05, 0x22 -> 0xFE. SRA 0x80, 0x02, 0x03 -> 0xE0. SRL 0x80, 0x02, 0x02 -> 0x20.
- TIMEOUT_CYCLES=16: send A=0x11 then nothing -> o_timeout pulse 16 cycles later, back in WAIT_A; next 0x01, 0x02, 0x20 -> 0x03, showing resync.
- Opcode byte 0x3F, then 0x60 (upper bit set), with ALU attached -> o_op_err pulse each time, result 0xA1 transmitted.
- rx_done with 0x99 during WAIT_TX -> o_overrun pulse, o_tx_data unchanged, next frame computes correctly.
- Assert i_rst_n low during SEND and during WAIT_OP -> all outputs 0 asynchronously, state WAIT_A, no o_tx_start after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check, default result
// and the controller FSM state encoding.
package alu_pkg;

    localparam logic [5:0] ADD_OP = 6'h20;
    localparam logic [5:0] SUB_OP = 6'h22;
    localparam logic [5:0] AND_OP = 6'h24;
    localparam logic [5:0] OR_OP  = 6'h25;
    localparam logic [5:0] XOR_OP = 6'h26;
    localparam logic [5:0] NOR_OP = 6'h27;
    localparam logic [5:0] SRA_OP = 6'h03;
    localparam logic [5:0] SRL_OP = 6'h02;

    localparam logic [7:0] ALU_DEFAULT_RESULT = 8'hA1;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } ctrl_state_e;

    function automatic logic ALU_OP_LEGAL(input logic [5:0] op);
        return (op == ADD_OP) || (op == SUB_OP) || (op == AND_OP) ||
               (op == OR_OP)  || (op == XOR_OP) || (op == NOR_OP) ||
               (op == SRA_OP) || (op == SRL_OP);
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter; o_expired is a combinational pulse in the cycle the
// count sits at TIMEOUT_CYCLES-1 while running with no clearing byte.
module frame_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned   CW   = (NB_TIMEOUT > 0) ? NB_TIMEOUT : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    always_comb begin
        hit   = (TIMEOUT_CYCLES != 0) && i_run && !i_clear && (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if ((TIMEOUT_CYCLES == 0) || !i_run || i_clear || hit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = hit;

endmodule

// File: rtl/alu_uart_ctrl.sv
// Byte sequencer between UART RX/TX and the combinational ALU: collects A, B and
// opcode, executes, returns the result, with timeout resync and error pulses.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_alu_data_A,
    output logic [NB_DATA-1:0] o_alu_data_B,
    output logic [4:0]         o_alu_shamt,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_op_err,
    output logic               o_overrun
);

    ctrl_state_e        state_q;
    logic [NB_DATA-1:0] a_q, b_q, tx_data_q;
    logic [NB_OP-1:0]   op_q;
    logic               op_bad_q;
    logic               tx_start_q, timeout_q, op_err_q, overrun_q;

    logic run, expired, op_bad, computing;

    assign run       = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign computing = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
    assign op_bad    = !ALU_OP_LEGAL(6'(i_rx_data[NB_OP-1:0])) || ((i_rx_data >> NB_OP) != '0);

    frame_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMEOUT     (NB_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_run     (run),
        .i_clear   (i_rx_done),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            op_bad_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            op_err_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            op_err_q   <= 1'b0;
            overrun_q  <= i_rx_done && computing;
            case (state_q)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        a_q     <= i_rx_data;
                        state_q <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        b_q     <= i_rx_data;
                        state_q <= ST_WAIT_OP;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        op_q     <= i_rx_data[NB_OP-1:0];
                        op_bad_q <= op_bad;
                        op_err_q <= op_bad;
                        state_q  <= ST_EXEC;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_WAIT_A;
                    end
                end
                ST_EXEC: begin
                    // Upper opcode bits never reach the ALU, so a rejected byte
                    // could still decode as legal there; send the default instead.
                    tx_data_q  <= op_bad_q ? NB_DATA'(ALU_DEFAULT_RESULT) : i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    state_q <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        state_q <= ST_WAIT_A;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_alu_op     = op_q;
    assign o_alu_data_A = a_q;
    assign o_alu_data_B = b_q;
    assign o_alu_shamt  = b_q[4:0];
    assign o_busy       = (state_q != ST_WAIT_A);
    assign o_timeout    = timeout_q;
    assign o_op_err     = op_err_q;
    assign o_overrun    = overrun_q;

endmodule
